// File: rtl/seven_seg_reader_if.sv
// Output word channel of seven_seg_reader: 1-deep valid/ready handshake.
//   out_valid   : word available (producer -> consumer)
//   out_ready   : consumer accepts current word (consumer -> producer)
//   out_digit   : digit 0-9, 4'hF for blank/invalid
//   out_pattern : 0 = number/blank, 2 = b,c,d,e,f lit, 3 = g only
//   out_invalid : settled pattern matched no known code
interface seven_seg_reader_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic [1:0] out_pattern;
  logic       out_invalid;

  modport master (
    output out_valid,
    output out_digit,
    output out_pattern,
    output out_invalid,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_digit,
    input  out_pattern,
    input  out_invalid,
    output out_ready
  );
endinterface

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: reads a raw 7-segment drive bus back into digit/pattern codes.
// Pipeline: 2-flop synchroniser -> stability filter -> classifier -> 1-deep
// valid/ready output register. A settled pattern is emitted once; repeats of
// the last emitted pattern are suppressed.
//   clk, rst_n      : clock, asynchronous active-low reset
//   seg[6:0]        : raw segment lines, seg[6]=a .. seg[0]=g (asynchronous)
//   common_cathode  : 1 = lit when high, 0 = lit when low (quasi-static)
//   clr_overrun     : synchronous clear of overrun (and err_count)
//   overrun         : sticky, a settled pattern was dropped while holding
//   out_bus         : output word channel (seven_seg_reader_if.master)
// Optional: define SEG_READER_ERRCNT_EN to add err_count[7:0], a saturating
// count of emitted words flagged invalid.
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg,
  input  logic                      common_cathode,
  input  logic                      clr_overrun,
  output logic                      overrun,
`ifdef SEG_READER_ERRCNT_EN
  output logic [7:0]                err_count,
`endif
  seven_seg_reader_if.master        out_bus
);

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PAT_W   = 2;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state, state_next;
  logic [SEG_W-1:0]     s1, s2;
  logic [SEG_W-1:0]     candidate;
  logic [CNT_W-1:0]     counter;
  logic [SEG_W-1:0]     tag;
  logic                 tag_valid;
  logic [DIGIT_W-1:0]   digit_q;
  logic [PAT_W-1:0]     pattern_q;
  logic                 invalid_q;

  logic [SEG_W-1:0]     lit_c;
  logic                 same_c;
  logic [CNT_W-1:0]     cnt_next_c;
  logic                 settled_c;
  logic                 new_settle_c;
  logic                 fresh_c;
  logic [DIGIT_W-1:0]   cls_digit_c;
  logic [PAT_W-1:0]     cls_pattern_c;
  logic                 cls_invalid_c;
  logic                 load_c;
  logic                 ovr_set_c;

  // Two-flop synchroniser on the raw segment lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= seg;
      s2 <= s1;
    end
  end

  // Stability filter: settled means the candidate will have been seen
  // STABLE_CYCLES times in a row after this edge; "new" is the first such edge.
  always_comb begin
    lit_c  = common_cathode ? s2 : ~s2;
    same_c = (lit_c == candidate);
    if (!same_c)
      cnt_next_c = CNT_W'(1);
    else if (counter == STABLE)
      cnt_next_c = counter;
    else
      cnt_next_c = counter + CNT_W'(1);
    settled_c    = (cnt_next_c == STABLE);
    new_settle_c = settled_c && !(same_c && (counter == STABLE));
    fresh_c      = settled_c && (!tag_valid || (lit_c != tag));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= '0;
      counter   <= '0;
    end else begin
      candidate <= lit_c;
      counter   <= cnt_next_c;
    end
  end

  // Classifier on the normalised lit pattern (a..g)
  always_comb begin
    cls_digit_c   = DIGIT_W'(4'hF);
    cls_pattern_c = PAT_W'(0);
    cls_invalid_c = 1'b0;
    case (lit_c)
      7'b1111110: cls_digit_c = DIGIT_W'(0);
      7'b0110000: cls_digit_c = DIGIT_W'(1);
      7'b1101101: cls_digit_c = DIGIT_W'(2);
      7'b1111001: cls_digit_c = DIGIT_W'(3);
      7'b0110011: cls_digit_c = DIGIT_W'(4);
      7'b1011011: cls_digit_c = DIGIT_W'(5);
      7'b1011111: cls_digit_c = DIGIT_W'(6);
      7'b1110000: cls_digit_c = DIGIT_W'(7);
      7'b1111111: cls_digit_c = DIGIT_W'(8);
      7'b1111011: cls_digit_c = DIGIT_W'(9);
      7'b0111110: begin
        cls_digit_c   = DIGIT_W'(0);
        cls_pattern_c = PAT_W'(2);
      end
      7'b0000001: begin
        cls_digit_c   = DIGIT_W'(0);
        cls_pattern_c = PAT_W'(3);
      end
      7'b0000000: cls_digit_c = DIGIT_W'(4'hF);
      default:    cls_invalid_c = 1'b1;
    endcase
  end

  // Output FSM: acceptance and reload may share an edge (no bubble)
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    ovr_set_c  = 1'b0;
    case (state)
      IDLE: begin
        if (fresh_c) begin
          load_c     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_bus.out_ready) begin
          if (fresh_c)
            load_c = 1'b1;
          else
            state_next = IDLE;
        end else if (new_settle_c && fresh_c) begin
          ovr_set_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Output word register and last-emitted tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q   <= '0;
      pattern_q <= '0;
      invalid_q <= 1'b0;
      tag       <= '0;
      tag_valid <= 1'b0;
    end else if (load_c) begin
      digit_q   <= cls_digit_c;
      pattern_q <= cls_pattern_c;
      invalid_q <= cls_invalid_c;
      tag       <= lit_c;
      tag_valid <= 1'b1;
    end
  end

  // Sticky overrun; a set on the same edge as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (ovr_set_c)
      overrun <= 1'b1;
    else if (clr_overrun)
      overrun <= 1'b0;
  end

`ifdef SEG_READER_ERRCNT_EN
  // Saturating count of invalid words, counted when loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (clr_overrun)
      err_count <= (load_c && cls_invalid_c) ? 8'd1 : 8'd0;
    else if (load_c && cls_invalid_c && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

  assign out_bus.out_valid   = (state == HOLD);
  assign out_bus.out_digit   = digit_q;
  assign out_bus.out_pattern = pattern_q;
  assign out_bus.out_invalid = invalid_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed scenarios with literal
// expectations plus randomized stimulus checked every cycle against a
// behavioural model (sample-history window, table lookup classifier).
module tb_seven_seg_reader;
  localparam int unsigned STABLE = 4;
  localparam logic [6:0] DIGS [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
    7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111,
    7'b1111011};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'd0;
  logic       cc = 1'b1;
  logic       clr = 1'b0;
  logic       overrun;
`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seven_seg_reader_if bus ();

  seven_seg_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .seg            (seg),
    .common_cathode (cc),
    .clr_overrun    (clr),
    .overrun        (overrun),
`ifdef SEG_READER_ERRCNT_EN
    .err_count      (err_count),
`endif
    .out_bus        (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void classify(input logic [6:0] p, output int d,
                                   output int pat, output bit inv);
    d = 15; pat = 0; inv = 1'b0;
    if (p == 7'd0) return;
    for (int i = 0; i < 10; i++)
      if (DIGS[i] == p) begin
        d = i;
        return;
      end
    if (p == 7'b0111110) begin d = 0; pat = 2; end
    else if (p == 7'b0000001) begin d = 0; pat = 3; end
    else inv = 1'b1;
  endfunction

  // ---------------- behavioural model ----------------
  logic [6:0] seg_q[$];
  logic [6:0] win[$];
  bit         m_prev_settled;
  logic [6:0] m_prev_val;
  int         m_tag;
  bit         m_valid;
  int         m_digit, m_pat;
  bit         m_inv, m_ovr;
  int         m_err;
  logic [6:0] m_s2, m_lit;
  bit         m_settled, m_newly, m_fresh, m_acc, m_set, m_inc;
  int         cd, cp;
  bit         ci;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q.delete(); win.delete();
      m_prev_settled = 1'b0; m_prev_val = 7'd0; m_tag = -1;
      m_valid = 1'b0; m_digit = 0; m_pat = 0; m_inv = 1'b0;
      m_ovr = 1'b0; m_err = 0;
    end else begin
      m_s2 = (seg_q.size() == 2) ? seg_q[0] : 7'd0;
      seg_q.push_back(seg);
      if (seg_q.size() > 2) void'(seg_q.pop_front());
      m_lit = cc ? m_s2 : ~m_s2;
      win.push_back(m_lit);
      if (win.size() > STABLE) void'(win.pop_front());
      m_settled = (win.size() == STABLE);
      foreach (win[i]) if (win[i] != m_lit) m_settled = 1'b0;
      m_newly = m_settled && !(m_prev_settled && (m_prev_val == m_lit));
      m_prev_settled = m_settled;
      m_prev_val = m_lit;
      m_fresh = m_settled && (int'(m_lit) != m_tag);
      m_acc = m_valid && bus.out_ready;
      m_set = 1'b0;
      m_inc = 1'b0;
      if (!m_valid || m_acc) begin
        if (m_fresh) begin
          classify(m_lit, cd, cp, ci);
          m_valid = 1'b1; m_digit = cd; m_pat = cp; m_inv = ci;
          m_tag = int'(m_lit);
          m_inc = ci;
        end else begin
          m_valid = 1'b0;
        end
      end else if (m_newly && m_fresh) begin
        m_set = 1'b1;
      end
      if (m_set) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (clr) m_err = m_inc ? 1 : 0;
      else if (m_inc && m_err < 255) m_err++;
    end
  end

  // Compare process: outputs are stable on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", int'(bus.out_valid), int'(m_valid));
      if (m_valid) begin
        check("digit", int'(bus.out_digit), m_digit);
        check("pattern", int'(bus.out_pattern), m_pat);
        check("invalid", int'(bus.out_invalid), int'(m_inv));
      end
      check("overrun", int'(overrun), int'(m_ovr));
`ifdef SEG_READER_ERRCNT_EN
      check("err_count", int'(err_count), m_err);
`endif
    end
  end

  // Transfer monitor: valid & ready at the falling edge completes on the next rise
  logic [6:0] wq[$];
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready)
      wq.push_back({bus.out_invalid, bus.out_pattern, bus.out_digit});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_word(input string name, input int d, input int p, input int inv);
    int t;
    logic [6:0] w;
    t = 0;
    while (wq.size() == 0 && t < 40) begin
      tick();
      t++;
    end
    if (wq.size() == 0) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      w = wq.pop_front();
      check({name, "_digit"}, int'(w[3:0]), d);
      check({name, "_pattern"}, int'(w[5:4]), p);
      check({name, "_invalid"}, int'(w[6]), inv);
    end
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!bus.out_valid && t < 40) begin
      tick();
      t++;
    end
    if (!bus.out_valid) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int lat;
    logic [6:0] p;
    int hold;
    bus.out_ready = 1'b1;
    cc  = 1'b1;
    seg = 7'b0110000;
    run(3);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_digit", int'(bus.out_digit), 0);
    check("rst_pattern", int'(bus.out_pattern), 0);
    rst_n = 1'b1;

    // Latency of a held digit 1 after reset
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (bus.out_valid) begin
        lat = e;
        break;
      end
    end
    check("latency", lat, 6);
    check("lat_digit", int'(bus.out_digit), 1);
    expect_word("w1", 1, 0, 0);
    run(20);
    check("no_repeat", wq.size(), 0);

    // Common anode codes
    cc = 1'b0; seg = ~7'b1111011;
    expect_word("ca9", 9, 0, 0);
    seg = ~7'b0000001;
    expect_word("ca_g", 0, 3, 0);
    seg = ~7'b0111110;
    expect_word("ca_bcdef", 0, 2, 0);

    // Glitch suppression and repeat suppression
    cc = 1'b1; seg = 7'b1111001;
    run(10); wq.delete();
    seg = 7'b0000000; run(2);
    seg = 7'b1111001; run(20);
    check("glitch_words", wq.size(), 0);

    // Overrun while holding
    bus.out_ready = 1'b0;
    seg = 7'b1011011;
    wait_valid("hold5");
    seg = 7'b1110000;
    run(12);
    check("hold_valid", int'(bus.out_valid), 1);
    check("hold_digit", int'(bus.out_digit), 5);
    check("ovr_set", int'(overrun), 1);
    bus.out_ready = 1'b1;
    expect_word("acc5", 5, 0, 0);
    expect_word("acc7", 7, 0, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovr_clr", int'(overrun), 0);

    // Invalid pattern
    seg = 7'b1010101;
    expect_word("inv", 15, 0, 1);
`ifdef SEG_READER_ERRCNT_EN
    check("errcnt1", int'(err_count), 1);
    for (int i = 0; i < 300; i++) begin
      seg = i[0] ? 7'b1010101 : 7'b0101010;
      run(8);
    end
    check("errcnt_sat", int'(err_count), 255);
`endif
    run(10); wq.delete();

    // Asynchronous reset while holding; same pattern re-emitted afterwards
    bus.out_ready = 1'b0;
    seg = 7'b0110011;
    wait_valid("hold4");
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    expect_word("reemit4", 4, 0, 0);

    // Randomized phase, checked by the compare process
    for (int s = 0; s < 500; s++) begin
      case ($urandom_range(0, 15))
        10:      p = 7'b0111110;
        11:      p = 7'b0000001;
        12:      p = 7'b0000000;
        13, 14, 15: p = 7'($urandom);
        default: p = DIGS[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 49) == 0) cc = ~cc;
      seg = cc ? p : ~p;
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
        clr = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    clr = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Reads a 7-segment drive bus back into symbols: takes raw segment lines (a..g) and returns the digit/pattern code that produced them.
- Pin-level counterpart of the digit-to-segment decoder. Used for display loopback self-test and for reading an external 7-segment source.
- Pipeline: synchronise → stability filter → classify → 1-deep valid/ready output register.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern counts as settled; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg  input  7  raw segment lines; seg[6]=a … seg[0]=g; asynchronous to clk
- common_cathode  input  1  1 = lit when high (CC); 0 = lit when low (CA); quasi-static
- out_ready  input  1  consumer accepts current word
- clr_overrun  input  1  synchronous clear of the overrun flag
- out_valid  output  1  word available
- out_digit  output  4  digit 0–9; 4'hF for blank
- out_pattern  output  2  0 = number/blank, 2 = b,c,d,e,f lit, 3 = g only
- out_invalid  output  1  settled pattern matches no known code
- overrun  output  1  sticky: a settled pattern was dropped

Behaviour:
- Reset values (async, rst_n low): sync flops 0, candidate 0, counter 0, all outputs 0. The last-emitted tag is set to "none", so the first settled pattern after reset is always emitted.
- Synchroniser: 2-flop on seg. Normalise after the second flop: lit = common_cathode ? s2 : ~s2.
- Stability filter:
  - lit != candidate → candidate <= lit, counter <= 1.
  - lit == candidate → counter increments, saturating at STABLE_CYCLES.
  - The pattern settles on the edge where counter reaches STABLE_CYCLES.
- Latency: a seg change held constant has out_valid high 2+STABLE_CYCLES edges after the first edge that samples it (6 edges at the default).
- Glitches shorter than STABLE_CYCLES synchronised cycles produce no output.
- Classification of lit[6:0] (a..g):
  - Digits: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9 → pattern 0.
  - All-lit is reported as digit 8, pattern 0. It is indistinguishable from "all on" by construction.
  - 0111110 → pattern 2, digit 0. 0000001 → pattern 3, digit 0.
  - 0000000 → blank: digit F, pattern 0.
  - Anything else → out_invalid=1, digit F, pattern 0.
- Emission: a settled pattern is emitted only if it differs from the last-emitted tag. The tag then updates to that pattern. The same pattern never emits twice in a row.
- FSM:
  - IDLE: out_valid=0. A settled new pattern loads the output register and moves to HOLD.
  - HOLD: out_valid=1; the output word is frozen.
  - out_valid & out_ready completes the transfer on that edge. Go to IDLE, or reload directly and stay in HOLD if a different settled pattern is present on that same edge (back-to-back, no bubble).
- Overrun: in HOLD with out_ready=0, a newly settled pattern different from both the held word and the last-emitted tag is dropped and sets overrun=1.
  - After the held word is accepted, the current settled pattern is emitted if it differs from the tag.
- overrun clears only on clr_overrun=1. Set has priority if clr_overrun and a set event occur on the same edge.
- A common_cathode change behaves like a seg change: it re-enters filtering.
- Reset mid-operation: any pending word is discarded and the tag returns to "none".

Optional Feature:
- Macro: SEG_READER_ERRCNT_EN.
- Defined: adds output err_count[7:0], counting emissions with out_invalid=1.
  - Saturates at 255.
  - Reset to 0 by rst_n and by clr_overrun.
  - Increments at load time, not at acceptance.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, CC=1, seg=0110000 held, out_ready=1 → out_valid at edge 6, digit=1, pattern=0, invalid=0; then no further words.
- CA (common_cathode=0), seg=~1111011 → digit=9. seg=~0000001 → pattern=3, digit=0. seg=~0111110 → pattern=2.
- CC, digit 3 settled, then a 2-cycle glitch to 0000000, then back to 3 → no word emitted for the glitch or for the repeated 3.
- out_ready=0: settle 5, then 7 → out_valid held on 5, overrun=1. Raise out_ready → 5 accepted, then 7 emitted. clr_overrun → overrun=0.
- seg=1010101 settled → out_invalid=1, digit=F. With SEG_READER_ERRCNT_EN, err_count=1, and saturates at 255 after 300 alternating invalid patterns.
- Drop rst_n while in HOLD → out_valid=0 immediately (async). Re-settle the same pattern after release → emitted again.
